// File: rtl/dmem_arbiter.sv
// Shares one word-organised data memory between the pipeline MEM stage (C) and a debug/loader master (D), adding byte-enable writes through a two-cycle read-modify-write.
// Latency: reads, full writes and empty writes take one cycle; partial writes take two. D read data arrives one cycle after d_gnt.
// Backpressure: C stalls while its request is not accepted. D is held until d_gnt, and gains priority after MAX_WAIT cycles of waiting.
module dmem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [3:0]  c_be,
  output logic        c_stall,
  output logic [31:0] c_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic [31:0] d_rdata,
  output logic        d_rvalid,
  output logic        mem_we,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  input  logic [31:0] mem_RD
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_RMW_WR = 1'b1;
  localparam logic [WAIT_W-1:0] L_MAX_WAIT = WAIT_W'(MAX_WAIT);

  logic [0:0]        r_state;
  logic              r_owner_d;    // 1 when D owns the RMW in progress
  logic [31:0]       r_merge;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [31:0]       r_d_rdata;
  logic              r_d_rvalid;

  logic        w_d_win;
  logic        w_c_win;
  logic        w_sel_d;
  logic        w_we;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [3:0]  w_be;
  logic        w_partial;
  logic        w_accept;
  logic        w_start_rmw;
  logic        w_mem_we;
  logic        w_c_accept;
  logic        w_d_accept;
  logic [31:0] w_merge_nxt;

  // Byte offset bits never reach the word-organised memory; lanes come from be.
  logic w_unused;
  assign w_unused = &{1'b0, c_addr[1:0], d_addr[1:0]};

  // Arbitration and per-cycle operation decode; RMW_WR locks the owner.
  always_comb begin
    w_d_win     = d_req && (!c_req || (r_wait_cnt >= L_MAX_WAIT));
    w_c_win     = c_req && !w_d_win;
    w_sel_d     = (r_state == S_RMW_WR) ? r_owner_d : w_d_win;
    w_we        = w_sel_d ? d_we    : c_we;
    w_addr      = w_sel_d ? d_addr  : c_addr;
    w_wdata     = w_sel_d ? d_wdata : c_wdata;
    w_be        = w_sel_d ? d_be    : c_be;
    w_partial   = w_we && (w_be != 4'hF) && (w_be != 4'h0);
    w_accept    = 1'b0;
    w_start_rmw = 1'b0;
    w_mem_we    = 1'b0;
    if (rst) begin
      if (r_state == S_RMW_WR) begin
        w_mem_we = 1'b1;
        w_accept = 1'b1;
      end else if (w_d_win || w_c_win) begin
        if (w_partial) begin
          w_start_rmw = 1'b1;
        end else begin
          w_accept = 1'b1;
          w_mem_we = w_we && (w_be == 4'hF);
        end
      end
    end
    w_c_accept = w_accept && !w_sel_d;
    w_d_accept = w_accept && w_sel_d;
  end

  // Merge new write lanes over the word read in the first RMW cycle.
  always_comb begin
    w_merge_nxt = 32'h0;
    for (int i = 0; i < 4; i++) begin
      w_merge_nxt[8*i +: 8] = w_be[i] ? w_wdata[8*i +: 8] : mem_RD[8*i +: 8];
    end
  end

  assign mem_we  = w_mem_we;
  assign mem_A   = {w_addr[31:2], 2'b00};
  assign mem_WD  = (r_state == S_RMW_WR) ? r_merge : w_wdata;
  assign c_stall = c_req && !w_c_accept;
  assign c_rdata = mem_RD;
  assign d_gnt   = w_d_accept;
  assign d_rdata = r_d_rdata;
  assign d_rvalid = r_d_rvalid;

  // FSM: enter RMW_WR on a partial write, always return to IDLE after one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_owner_d <= 1'b0;
      r_merge   <= 32'h0;
    end else if (w_start_rmw) begin
      r_state   <= S_RMW_WR;
      r_owner_d <= w_sel_d;
      r_merge   <= w_merge_nxt;
    end else if (r_state == S_RMW_WR) begin
      r_state   <= S_IDLE;
    end
  end

  // D starvation counter: counts unaccepted D request cycles, saturating.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wait_cnt <= '0;
    end else if (!d_req || w_d_accept) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt < L_MAX_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Capture D read data on the edge after a D read accept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_d_rdata  <= 32'h0;
      r_d_rvalid <= 1'b0;
    end else begin
      r_d_rvalid <= w_d_accept && !d_we;
      if (w_d_accept && !d_we) begin
        r_d_rdata <= mem_RD;
      end
    end
  end

endmodule
